// File: rtl/rob_commit_unit_if.sv
// Signal bundle between the reorder buffer and its neighbours: dispatch, two
// writeback lanes, the commit-store handshake, retire ports and the flush request.
interface rob_commit_unit_if #(
    parameter int DEPTH = 16
) ();
    localparam int IW = $clog2(DEPTH);

    logic [1:0]          dispatch_valid;
    logic [1:0]          dispatch_store;
    logic [1:0][4:0]     dispatch_dest;
    logic [1:0][31:0]    dispatch_pc;
    logic                dispatch_ready;
    logic [1:0][IW-1:0]  dispatch_idx;

    logic                wb1_valid;
    logic [IW-1:0]       wb1_idx;
    logic                wb1_ex;
    logic [4:0]          wb1_excode;
    logic [31:0]         wb1_result;
    logic                wb2_valid;
    logic [IW-1:0]       wb2_idx;
    logic                wb2_ex;
    logic [4:0]          wb2_excode;
    logic [31:0]         wb2_result;

    logic                commit_store_valid;
    logic                commit_store_ready;
    logic                commit_store_ex;

    logic [1:0]          retire_valid;
    logic [1:0][4:0]     retire_dest;
    logic [1:0][31:0]    retire_data;

    logic                flush;
    logic [31:0]         flush_pc;
    logic [4:0]          flush_excode;

    modport slave (
        input  dispatch_valid, dispatch_store, dispatch_dest, dispatch_pc,
        output dispatch_ready, dispatch_idx,
        input  wb1_valid, wb1_idx, wb1_ex, wb1_excode, wb1_result,
        input  wb2_valid, wb2_idx, wb2_ex, wb2_excode, wb2_result,
        output commit_store_valid,
        input  commit_store_ready, commit_store_ex,
        output retire_valid, retire_dest, retire_data,
        output flush, flush_pc, flush_excode
    );

    modport master (
        output dispatch_valid, dispatch_store, dispatch_dest, dispatch_pc,
        input  dispatch_ready, dispatch_idx,
        output wb1_valid, wb1_idx, wb1_ex, wb1_excode, wb1_result,
        output wb2_valid, wb2_idx, wb2_ex, wb2_excode, wb2_result,
        input  commit_store_valid,
        output commit_store_ready, commit_store_ex,
        input  retire_valid, retire_dest, retire_data,
        input  flush, flush_pc, flush_excode
    );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: dual dispatch, dual writeback, up to two retires per
// cycle, store commit handshake and a one-cycle flush for exceptions at the head.
module rob_commit_unit #(
    parameter int DEPTH = 16
) (
    input logic              clk,
    input logic              reset,
    rob_commit_unit_if.slave bus
);
    localparam int         IW               = $clog2(DEPTH);
    localparam int         PW               = IW + 1;
    localparam logic [4:0] STORE_FAULT_CODE = 5'h05;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        store;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] result;
    } entry_t;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    count;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    entry_t           ent [DEPTH];

    logic [IW-1:0] h0, h1, t0, t1;
    logic          h0_ready, h1_ready;
    logic          exc_flush, store_head, store_fault;
    logic          ret0, ret1, flush_now, accept;

    assign count = tail - head;
    assign h0    = head[IW-1:0];
    assign h1    = h0 + IW'(1);
    assign t0    = tail[IW-1:0];
    assign t1    = t0 + IW'(1);

    assign h0_ready    = busy[h0] & done[h0];
    assign h1_ready    = busy[h1] & done[h1] & ~ent[h1].ex & ~ent[h1].store;
    assign exc_flush   = h0_ready & ent[h0].ex;
    assign store_head  = h0_ready & ~ent[h0].ex & ent[h0].store;
    assign store_fault = store_head & bus.commit_store_ready & bus.commit_store_ex;

    // A store at the head retires only in the cycle the load/store unit accepts it cleanly.
    assign ret0 = h0_ready & ~ent[h0].ex
                & (~ent[h0].store | (bus.commit_store_ready & ~bus.commit_store_ex));
    assign ret1 = h0_ready & ~ent[h0].ex & ~ent[h0].store & h1_ready;

    assign flush_now = exc_flush | store_fault;
    assign accept    = bus.dispatch_ready & bus.dispatch_valid[0];

    assign bus.dispatch_ready     = (count <= PW'(DEPTH - 2));
    assign bus.dispatch_idx[0]    = t0;
    assign bus.dispatch_idx[1]    = t1;
    assign bus.commit_store_valid = store_head;
    assign bus.retire_valid       = {ret1, ret0};
    assign bus.flush              = flush_now;

    always_comb begin
        // NOTE: every output driven here gets a default first so no path infers a latch.
        bus.retire_dest  = '0;
        bus.retire_data  = '0;
        bus.flush_pc     = '0;
        bus.flush_excode = '0;
        if (ret0) begin
            bus.retire_dest[0] = ent[h0].dest;
            bus.retire_data[0] = ent[h0].result;
        end
        if (ret1) begin
            bus.retire_dest[1] = ent[h1].dest;
            bus.retire_data[1] = ent[h1].result;
        end
        if (exc_flush) begin
            bus.flush_pc     = ent[h0].pc;
            bus.flush_excode = ent[h0].excode;
        end else if (store_fault) begin
            bus.flush_pc     = ent[h0].pc;
            bus.flush_excode = STORE_FAULT_CODE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every read in this block sees pre-edge state.
        if (reset || flush_now) begin
            head <= '0;
            tail <= '0;
            busy <= '0;
            done <= '0;
        end else begin
            if (bus.wb2_valid && busy[bus.wb2_idx]) done[bus.wb2_idx] <= 1'b1;
            if (bus.wb1_valid && busy[bus.wb1_idx]) done[bus.wb1_idx] <= 1'b1;
            if (ret0) busy[h0] <= 1'b0;
            if (ret1) busy[h1] <= 1'b0;
            if (accept) begin
                busy[t0] <= 1'b1;
                done[t0] <= 1'b0;
                if (bus.dispatch_valid[1]) begin
                    busy[t1] <= 1'b1;
                    done[t1] <= 1'b0;
                end
                tail <= tail + (bus.dispatch_valid[1] ? PW'(2) : PW'(1));
            end
            head <= head + PW'(ret0) + PW'(ret1);
        end
    end

    // NOTE: the payload array is intentionally not reset; busy/done gate every use of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent[t0].store <= bus.dispatch_store[0];
            ent[t0].dest  <= bus.dispatch_dest[0];
            ent[t0].pc    <= bus.dispatch_pc[0];
            if (bus.dispatch_valid[1]) begin
                ent[t1].store <= bus.dispatch_store[1];
                ent[t1].dest  <= bus.dispatch_dest[1];
                ent[t1].pc    <= bus.dispatch_pc[1];
            end
        end
        // Lane 1 is written last so it wins when both lanes name the same entry.
        if (bus.wb2_valid && busy[bus.wb2_idx]) begin
            ent[bus.wb2_idx].ex     <= bus.wb2_ex;
            ent[bus.wb2_idx].excode <= bus.wb2_excode;
            ent[bus.wb2_idx].result <= bus.wb2_result;
        end
        if (bus.wb1_valid && busy[bus.wb1_idx]) begin
            ent[bus.wb1_idx].ex     <= bus.wb1_ex;
            ent[bus.wb1_idx].excode <= bus.wb1_excode;
            ent[bus.wb1_idx].result <= bus.wb1_result;
        end
    end
endmodule
